// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter sharing the host transmitter,
// locking the grant for the duration of a message.
module tx_arbiter #(
  parameter int NREQ     = 3,
  parameter int DW       = 32,
  parameter int LOCK_TMO = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              abort,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*3-1:0] req_bytes,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_send,
  output logic [DW-1:0]     tx_data,
  output logic [2:0]        tx_bytes,
  input  logic              tx_busy,
  output logic [1:0]        grant_id,
  output logic              locked,
  output logic              arb_busy,
  output logic              tmo_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  localparam int TW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO + 1) : 1;

  state_t          state, state_nx;
  logic [1:0]      rr_ptr;
  logic [1:0]      cand;
  logic [1:0]      next_ptr;
  logic [2:0]      scan_idx;
  logic            cand_found;
  logic            accept;
  logic            last_r;
  logic            done_last;
  logic            tmo_run;
  logic            tmo_fire;
  logic [TW-1:0]   tmo_cnt;
  logic [DW-1:0]   cand_data;
  logic [2:0]      cand_bytes;

  // While locked only the owner may continue; otherwise scan upward from rr_ptr.
  always_comb begin
    cand_found = 1'b0;
    cand       = 2'd0;
    scan_idx   = 3'd0;
    if (locked) begin
      cand       = grant_id;
      cand_found = req_valid[grant_id];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = {1'b0, rr_ptr} + 3'(k);
        if (scan_idx >= 3'(NREQ))
          scan_idx = scan_idx - 3'(NREQ);
        if (!cand_found && req_valid[scan_idx[1:0]]) begin
          cand_found = 1'b1;
          cand       = scan_idx[1:0];
        end
      end
    end
  end

  assign cand_data  = req_data[int'(cand)*DW +: DW];
  assign cand_bytes = req_bytes[int'(cand)*3 +: 3];
  assign accept     = (state == IDLE) && cand_found && !abort;

  always_comb begin
    req_ready = '0;
    if (accept && !sys_rst)
      req_ready[cand] = 1'b1;
  end

  assign next_ptr  = (grant_id == 2'(NREQ - 1)) ? 2'd0 : grant_id + 2'd1;
  assign done_last = (state == WAIT_DONE) && !tx_busy && last_r;
  assign tmo_run   = (LOCK_TMO != 0) && (state == IDLE) && locked && !req_valid[grant_id];
  assign tmo_fire  = tmo_run && (tmo_cnt == TW'(LOCK_TMO - 1));

  assign tx_send  = (state == SEND);
  assign arb_busy = (state != IDLE) || locked;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (accept) state_nx = SEND;
      SEND:      state_nx = WAIT_ACK;
      WAIT_ACK:  state_nx = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_bytes <= 3'd0;
      last_r   <= 1'b0;
      grant_id <= 2'd0;
      locked   <= 1'b0;
      rr_ptr   <= 2'd0;
      tmo_cnt  <= '0;
      tmo_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        tx_data  <= cand_data;
        tx_bytes <= (cand_bytes == 3'd0) ? 3'd4 : cand_bytes;
        last_r   <= req_last[cand];
        grant_id <= cand;
      end
      if (tmo_run && !abort)
        tmo_cnt <= tmo_fire ? '0 : tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      // A word already handed to the transmitter still advances the pointer when it ends a message.
      if (done_last || (tmo_fire && !abort))
        rr_ptr <= next_ptr;
      if (abort) begin
        locked  <= 1'b0;
        tmo_err <= 1'b0;
      end else if (accept) begin
        locked <= 1'b1;
      end else if (done_last) begin
        locked <= 1'b0;
      end else if (tmo_fire) begin
        locked  <= 1'b0;
        tmo_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares the single host transmitter (the `outputSend`/`outputBusy` word interface) among up to four requesters: sample readout from the capture controller, metadata/ID responses, status reports and similar sources. Each requester offers 32-bit words with a byte count and a last-of-message marker. The arbiter grants round-robin and locks the grant until the last word of a message has been sent, so messages never interleave on the link. It runs entirely in the core clock domain, between the sources and the transmitter.

## Interface
- `NREQ`, default 3: number of requesters, legal 2..4.
- `DW`, default 32: word width.
- `LOCK_TMO`, default 1024: idle cycles a locked requester may stall before its lock is revoked. 0 disables the timeout.

Ports:
- `sys_clk` in 1: core clock; only clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `abort` in 1: cancel in-progress messages (driven by the reset command).
- `req_valid` in NREQ: per-requester word valid.
- `req_data` in NREQ*DW: requester i data occupies `[i*DW +: DW]`.
- `req_bytes` in NREQ*3: requester i byte count occupies `[i*3 +: 3]`. Legal values 1..4; 0 means 4.
- `req_last` in NREQ: word is the last of its message.
- `req_ready` out NREQ: one-hot accept strobe.
- `tx_send` out 1: one-cycle send strobe to the transmitter.
- `tx_data` out DW: word to transmit.
- `tx_bytes` out 3: byte count, 1..4.
- `tx_busy` in 1: transmitter busy.
- `grant_id` out 2: current or last granted requester.
- `locked` out 1: a message is in progress.
- `arb_busy` out 1: high when state != IDLE or `locked`=1.
- `tmo_err` out 1: sticky flag, set when a lock timeout fires.

## Operation
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE.
- **Selection in IDLE.**
  - Unlocked: candidate = first i with `req_valid[i]`, scanning upward from `rr_ptr` and wrapping modulo NREQ.
  - Locked: the only candidate is `grant_id`.
- **Transfer in IDLE.** If a candidate exists and `abort`=0:
  - `req_ready[cand]`=1 combinationally in that same cycle.
  - Register `tx_data`, `tx_bytes` (0 mapped to 4), last flag and `grant_id`=cand.
  - Set `locked`=1 and go to SEND.
- **Requester rule.** `req_valid` must hold with stable data until `req_ready`. `req_ready` is never asserted outside IDLE.
- **SEND:** `tx_send`=1 for exactly one cycle, then WAIT_ACK.
- **WAIT_ACK:** one cycle in which `tx_busy` is ignored (the transmitter raises busy one cycle after send), then WAIT_DONE.
- **WAIT_DONE:** wait for `tx_busy`=0, then go to IDLE.
  - If the captured last flag=1: clear `locked` and set `rr_ptr`=(`grant_id`+1) mod NREQ.
  - Otherwise keep the lock.
- **Lock timeout.** A counter runs while in IDLE with `locked`=1 and `req_valid[grant_id]`=0; it is cleared otherwise. When it reaches LOCK_TMO (with LOCK_TMO≠0): clear `locked`, set `rr_ptr`=`grant_id`+1 and set `tmo_err`.
- **Abort.**
  - In any state: clear `locked` at the end of that cycle and clear `tmo_err`.
  - In IDLE: no transfer occurs that cycle.
  - In SEND/WAIT_*: the word already handed to the transmitter completes normally; no further words are taken from that message.
  - `rr_ptr` is unchanged by abort.
- **Simultaneous events:**
  - Abort takes priority over the timeout.
  - A timeout and a new `req_valid[grant_id]` arriving in the same cycle: the transfer wins and the counter clears.
- **Reset values:** all outputs 0; `rr_ptr`=0; counter=0; state=IDLE.

## Timing
- Accept-to-send latency: `req_ready` at cycle t, `tx_send` at t+1.
- Minimum word period: 4 cycles (IDLE, SEND, WAIT_ACK, and WAIT_DONE with `tx_busy` already low).
- `tx_data` and `tx_bytes` are stable from t+1 until the next accept.
- `grant_id` changes only on an accept.
- `locked` falls in the cycle after WAIT_DONE exits on a last word.
- A `sys_rst` mid-message returns to IDLE the next cycle with `tx_send`=0. Reset does not wait for `tx_busy`.

## Test plan
- **Single word.** Requester 0 sends 0xA5A5_0001 with bytes=4, last=1; `tx_busy` high for cycles t+2..t+5.
  - Required: `req_ready[0]` at t; `tx_send` only at t+1 with `tx_data`=0xA5A5_0001 and `tx_bytes`=4.
  - Required: `locked` low after busy drops; `rr_ptr`=1.
- **Round-robin.** Requesters 0, 1 and 2 all hold valid single-word messages.
  - Required: grants in order 0, 1, 2, then 0 again when 0 re-requests. `req_ready` stays one-hot.
- **Lock.** Requester 1 sends a 3-word message (last on word 3) while requester 2 has valid held high throughout.
  - Required: all 3 words from requester 1 are sent before requester 2's first `req_ready`.
- **Timeout.** LOCK_TMO=8; requester 0 sends a non-last word, then drops valid; requester 1 is valid.
  - Required: after 8 idle cycles, `tmo_err`=1 and `locked`=0; the next grant goes to requester 1.
- **Abort mid-message.** Assert `abort` in WAIT_ACK of word 2 of a 4-word message.
  - Required: word 2 completes with exactly one `tx_send`; `locked`=0 and `tmo_err`=0; the requester's word 3 is not accepted until it is regranted by round-robin.
- **Bytes mapping and reset.** Send with `req_bytes`=0 and expect `tx_bytes`=4. Assert `sys_rst` during WAIT_DONE.
  - Required: all outputs are 0 on the next cycle and state is IDLE.
